// File: rtl/mips_loader_pkg.sv
// Shared types and frame constants for the MIPS program loader.
package mips_loader_pkg;

  typedef enum logic [6:0] {
    StIdle  = 7'b0000001,
    StLenHi = 7'b0000010,
    StLenLo = 7'b0000100,
    StData  = 7'b0001000,
    StCsum  = 7'b0010000,
    StRun   = 7'b0100000,
    StErr   = 7'b1000000
  } state_e;

  localparam int unsigned LenBytes  = 2;
  localparam int unsigned WordBytes = 4;

endpackage

// File: rtl/mips_program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface mips_program_loader_if #(
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH  = 7
);

  logic [7:0]             in_byte;
  logic                   in_valid;
  logic                   in_ready;
  logic                   imem_we;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [INSTR_WIDTH-1:0] imem_wdata;

  // Loader side: sinks the stream, drives the memory write port.
  modport master (
    input  in_byte,
    input  in_valid,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  // Host/memory side.
  modport slave (
    output in_byte,
    output in_valid,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

endinterface

// File: rtl/byte_packer.sv
// Assembles big-endian bytes into instruction words; flags each completed word for one cycle.
module byte_packer
  import mips_loader_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   byte_valid_i,
  input  logic [7:0]             byte_i,
  output logic                   last_byte_o,
  output logic                   word_valid_o,
  output logic [INSTR_WIDTH-1:0] word_o
);

  logic [1:0]             cnt_q;
  logic [INSTR_WIDTH-1:0] shift_q;
  logic                   valid_q;

  assign last_byte_o  = (cnt_q == 2'(WordBytes - 1));
  assign word_valid_o = valid_q;
  assign word_o       = shift_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= 2'd0;
      shift_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= byte_valid_i & last_byte_o;
      if (clear_i) begin
        cnt_q <= 2'd0;
      end else if (byte_valid_i) begin
        cnt_q   <= cnt_q + 2'd1;
        shift_q <= {shift_q[INSTR_WIDTH-9:0], byte_i};
      end
    end
  end

endmodule

// File: rtl/mips_program_loader.sv
// Loads a framed, checksummed program image into instruction memory and holds the core in
// reset until the image is verified.
module mips_program_loader
  import mips_loader_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned MEM_DEPTH   = 100,
  parameter int unsigned ADDR_WIDTH  = 7
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  mips_program_loader_if.master bus,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned          LenWidth = 8 * LenBytes;
  localparam logic [LenWidth-1:0]  MaxLen   = LenWidth'(MEM_DEPTH);

  state_e                 state_q, state_d;
  logic                   fire, clear, last_byte, word_valid;
  logic                   len_bad, last_word, csum_ok;
  logic [7:0]             len_hi_q, xor_q;
  logic [LenWidth-1:0]    len_w;
  logic [ADDR_WIDTH-1:0]  last_idx_q, word_idx_q, addr_q;
  logic [INSTR_WIDTH-1:0] word;

  assign fire      = bus.in_valid & bus.in_ready;
  assign clear     = start & ((state_q == StIdle) | (state_q == StRun) | (state_q == StErr));
  assign len_w     = {len_hi_q, bus.in_byte};
  assign len_bad   = (len_w == '0) || (len_w > MaxLen);
  assign last_word = (word_idx_q == last_idx_q);
  assign csum_ok   = (bus.in_byte == xor_q);

  byte_packer #(
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_byte_packer (
    .clk_i        (CLK),
    .rst_i        (RST),
    .clear_i      (clear),
    .byte_valid_i (fire & (state_q == StData)),
    .byte_i       (bus.in_byte),
    .last_byte_o  (last_byte),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StRun, StErr: if (start) state_d = StLenHi;
      StLenHi:              if (fire) state_d = StLenLo;
      StLenLo:              if (fire) state_d = len_bad ? StErr : StData;
      StData:               if (fire && last_byte && last_word) state_d = StCsum;
      StCsum:               if (fire) state_d = csum_ok ? StRun : StErr;
      default:              state_d = StIdle;
    endcase
  end

  // Status outputs are decodes of the one-hot state flops.
  always_comb begin
    bus.in_ready = 1'b0;
    cpu_rst      = 1'b1;
    done         = 1'b0;
    error        = 1'b0;
    unique case (state_q)
      StLenHi, StLenLo, StData, StCsum: bus.in_ready = 1'b1;
      StRun: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
      end
      StErr:   error = 1'b1;
      default: ;
    endcase
  end

  // addr_q latches the index of the word being written so imem_addr lines up with imem_we.
  always_ff @(posedge CLK) begin
    if (RST) begin
      len_hi_q   <= 8'd0;
      last_idx_q <= '0;
      word_idx_q <= '0;
      xor_q      <= 8'd0;
      addr_q     <= '0;
    end else if (clear) begin
      word_idx_q <= '0;
      xor_q      <= 8'd0;
    end else if (fire) begin
      if (state_q == StLenHi) len_hi_q <= bus.in_byte;
      if (state_q == StLenLo) last_idx_q <= ADDR_WIDTH'(len_w - LenWidth'(1));
      if (state_q == StData) begin
        xor_q <= xor_q ^ bus.in_byte;
        if (last_byte) begin
          addr_q     <= word_idx_q;
          word_idx_q <= word_idx_q + ADDR_WIDTH'(1);
        end
      end
    end
  end

  assign bus.imem_we    = word_valid;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word;

endmodule

// File: tb/tb_mips_program_loader.sv
// Directed and randomized image loads checked against a frame-level model of the loader.
module tb_mips_program_loader;

  logic CLK = 1'b0;
  logic RST, start;
  logic cpu_rst, done, error;

  mips_program_loader_if #(.INSTR_WIDTH(32), .ADDR_WIDTH(7)) bus ();

  mips_program_loader #(
    .INSTR_WIDTH (32),
    .MEM_DEPTH   (100),
    .ADDR_WIDTH  (7)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .start   (start),
    .bus     (bus),
    .cpu_rst (cpu_rst),
    .done    (done),
    .error   (error)
  );

  always #5 CLK = ~CLK;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [6:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  bit   [31:0] img[$];

  // Every cycle with imem_we high is one captured write.
  always @(negedge CLK) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic rdy, input logic cr, input logic dn,
                           input logic er);
    chk({tag, " in_ready"}, {31'd0, bus.in_ready}, {31'd0, rdy});
    chk({tag, " cpu_rst"},  {31'd0, cpu_rst},      {31'd0, cr});
    chk({tag, " done"},     {31'd0, done},         {31'd0, dn});
    chk({tag, " error"},    {31'd0, error},        {31'd0, er});
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int wait_cnt;
    gap      = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    wait_cnt = 0;
    repeat (gap) begin
      @(negedge CLK);
      bus.in_valid = 1'b0;
    end
    @(negedge CLK);
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && wait_cnt < 20) begin
      @(negedge CLK);
      wait_cnt++;
    end
    if (wait_cnt >= 20) chk("in_ready timeout", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic idle();
    @(negedge CLK);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Sends a frame built from img; csum_flip != 0 corrupts the checksum byte.
  task automatic run_image(input int len, input logic [7:0] csum_flip, input int max_gap,
                           input string tag);
    logic [15:0] l16;
    logic [7:0]  x;
    logic [7:0]  by;
    bit          len_bad;
    bit          good;
    int          exp_writes;
    l16     = 16'(len);
    x       = 8'd0;
    len_bad = (len == 0) || (len > 100);
    wr_addr.delete();
    wr_data.delete();
    send_byte(l16[15:8], max_gap);
    send_byte(l16[7:0], max_gap);
    if (!len_bad) begin
      for (int i = 0; i < len; i++) begin
        for (int b = 3; b >= 0; b--) begin
          by = img[i][8*b +: 8];
          x  = x ^ by;
          send_byte(by, max_gap);
        end
      end
      send_byte(x ^ csum_flip, max_gap);
    end
    idle();
    exp_writes = len_bad ? 0 : len;
    good       = !len_bad && (csum_flip == 8'd0);
    chk({tag, " write count"}, wr_addr.size(), exp_writes);
    for (int i = 0; i < wr_addr.size() && i < exp_writes; i++) begin
      chk($sformatf("%s addr[%0d]", tag, i), {25'd0, wr_addr[i]}, i);
      chk($sformatf("%s data[%0d]", tag, i), wr_data[i], img[i]);
    end
    chk_flags(tag, 1'b0, !good, good, !good);
  endtask

  int         n;
  logic [7:0] flip;

  initial begin
    RST          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'd0;
    repeat (2) @(negedge CLK);
    chk_flags("reset", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("reset imem_we", {31'd0, bus.imem_we}, 32'd0);
    chk("reset imem_addr", {25'd0, bus.imem_addr}, 32'd0);
    chk("reset imem_wdata", bus.imem_wdata, 32'd0);
    RST = 1'b0;

    img = '{32'h2008_0005, 32'hAC08_0000};
    pulse_start();
    run_image(2, 8'h00, 0, "good");

    pulse_start();
    chk_flags("reload start", 1'b1, 1'b1, 1'b0, 1'b0);
    img = '{32'h0000_0008};
    run_image(1, 8'h00, 0, "reload");

    img = '{32'h2008_0005, 32'hAC08_0000};
    pulse_start();
    run_image(2, 8'h89, 0, "bad csum");

    pulse_start();
    run_image(101, 8'h00, 0, "len 101");
    pulse_start();
    run_image(0, 8'h00, 0, "len 0");

    pulse_start();
    run_image(2, 8'h00, 3, "stall");

    pulse_start();
    wr_addr.delete();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h20, 0);
    send_byte(8'h08, 0);
    @(negedge CLK);
    RST          = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge CLK);
    chk_flags("mid rst", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mid rst imem_we", {31'd0, bus.imem_we}, 32'd0);
    chk("mid rst imem_addr", {25'd0, bus.imem_addr}, 32'd0);
    chk("mid rst imem_wdata", bus.imem_wdata, 32'd0);
    chk("mid rst no writes", wr_addr.size(), 0);
    RST = 1'b0;
    pulse_start();
    run_image(2, 8'h00, 0, "after rst");

    for (int k = 0; k < 6; k++) begin
      n = int'($urandom_range(8, 1));
      img.delete();
      repeat (n) img.push_back($urandom);
      flip = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'd0;
      pulse_start();
      run_image(n, flip, int'($urandom_range(3, 0)), $sformatf("rand%0d", k));
    end

    img.delete();
    repeat (100) img.push_back($urandom);
    pulse_start();
    run_image(100, 8'h00, 1, "len 100");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
